// File: rtl/period_scheduler.sv
// period_scheduler: sequences an external prescaler counter chain, counting its
// terminal carries and pulsing done after the commanded number of periods.
// Optional macro PERIOD_RELOAD_EN: reload and loop instead of stopping after each command.
`default_nettype none

module period_scheduler #(
  parameter int W = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [W-1:0] periods_i,
  input  logic         hold_i,
  input  logic         abort_i,
  input  logic         eu_i,
  output logic         ei_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] remaining_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         ei_q, ei_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] rem_q, rem_d;

  logic w_carry;
  logic w_last;
  logic w_zero_cmd;

  // A carry only counts when the chain was actually enabled in that cycle.
  assign w_carry    = eu_i & ei_q;
  assign w_last     = (rem_q == W'(1));
  assign w_zero_cmd = (periods_i == '0);

`ifdef PERIOD_RELOAD_EN
  logic [W-1:0] periods_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      periods_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      periods_q <= periods_i;
    end
  end
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ei_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ei_q    <= ei_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = w_zero_cmd ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (w_carry && w_last) begin
`ifdef PERIOD_RELOAD_EN
          state_d = S_RUN;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ei_d   = 1'b0;
    done_d = 1'b0;
    rem_d  = rem_q;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rem_d  = periods_i;
          ei_d   = ~w_zero_cmd;
          done_d = w_zero_cmd;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          rem_d = '0;
        end else if (w_carry && w_last) begin
          done_d = 1'b1;
`ifdef PERIOD_RELOAD_EN
          rem_d  = periods_q;
          ei_d   = 1'b1;
`else
          rem_d  = '0;
`endif
        end else begin
          ei_d = ~hold_i;
          if (w_carry) begin
            rem_d = rem_q - W'(1);
          end
        end
      end
      default: begin
        ei_d = 1'b0;
      end
    endcase
  end

  assign ei_o        = ei_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign remaining_o = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_period_scheduler.sv
// Directed bench for period_scheduler; expected outputs are queued per step and
// compared one cycle later against the registered outputs.
`default_nettype none

module tb_period_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, hold, abort, eu;
  logic [W-1:0] periods;
  logic         ei, busy, done;
  logic [W-1:0] remaining;

  logic [W+2:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  period_scheduler #(.W(W)) dut (
    .clock_i     (clk),
    .reset_i     (reset),
    .start_i     (start),
    .periods_i   (periods),
    .hold_i      (hold),
    .abort_i     (abort),
    .eu_i        (eu),
    .ei_o        (ei),
    .busy_o      (busy),
    .done_o      (done),
    .remaining_o (remaining)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
  task automatic step(input string tag, input logic rs, input logic st, input logic [W-1:0] p,
                      input logic hd, input logic ab, input logic e,
                      input logic x_ei, input logic x_busy, input logic x_done,
                      input logic [W-1:0] x_rem);
    logic [W+2:0] obs;
    logic [W+2:0] expv;
    @(negedge clk);
    reset   = rs;
    start   = st;
    periods = p;
    hold    = hd;
    abort   = ab;
    eu      = e;
    exp_q.push_back({x_ei, x_busy, x_done, x_rem});
    @(posedge clk);
    #1;
    expv = exp_q.pop_front();
    obs  = {ei, busy, done, remaining};
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed ei/busy/done/rem=%b/%b/%b/%0d expected=%b/%b/%b/%0d", tag,
             obs[W+2], obs[W+1], obs[W], obs[W-1:0], expv[W+2], expv[W+1], expv[W], expv[W-1:0]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; eu = 1'b0; periods = '0;

    //   tag          rs st  p  hd ab eu   ei busy done rem
    step("rst0",      1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step("rst1",      1, 1, 5, 0, 0, 1,   0, 0, 0, 0);
    step("rel",       0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step("idle_abort",0, 0, 0, 0, 1, 1,   0, 0, 0, 0);

`ifdef PERIOD_RELOAD_EN
    step("rl_start",  0, 1, 2, 0, 0, 0,   1, 1, 0, 2);
    for (int i = 0; i < 3; i++) begin
      step("rl_c1",   0, 0, 0, 0, 0, 1,   1, 1, 0, 1);
      step("rl_c2",   0, 0, 0, 0, 0, 1,   1, 1, 1, 2);
    end
    step("rl_abort",  0, 0, 0, 0, 1, 0,   0, 0, 0, 0);
`else
    // Three counted carries with one idle gap and an ignored start while running
    step("p3_start",  0, 1, 3, 0, 0, 0,   1, 1, 0, 3);
    step("p3_c1",     0, 0, 0, 0, 0, 1,   1, 1, 0, 2);
    step("p3_ign_st", 0, 1, 7, 0, 0, 0,   1, 1, 0, 2);
    step("p3_c2",     0, 0, 0, 0, 0, 1,   1, 1, 0, 1);
    step("p3_c3",     0, 0, 0, 0, 0, 1,   0, 1, 1, 0);
    step("p3_idle",   0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // Carries during hold are ignored, including the one-cycle ei latency after release
    step("h_start",   0, 1, 2, 0, 0, 0,   1, 1, 0, 2);
    step("h_c1",      0, 0, 0, 0, 0, 1,   1, 1, 0, 1);
    step("h_hold1",   0, 0, 0, 1, 0, 0,   0, 1, 0, 1);
    step("h_hold2",   0, 0, 0, 1, 0, 1,   0, 1, 0, 1);
    step("h_hold3",   0, 0, 0, 1, 0, 1,   0, 1, 0, 1);
    step("h_hold4",   0, 0, 0, 1, 0, 1,   0, 1, 0, 1);
    step("h_release", 0, 0, 0, 0, 0, 1,   1, 1, 0, 1);
    step("h_c2",      0, 0, 0, 0, 0, 1,   0, 1, 1, 0);
    step("h_idle",    0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // A carry sampled on the same edge hold rises still counts
    step("hc_start",  0, 1, 3, 0, 0, 0,   1, 1, 0, 3);
    step("hc_edge",   0, 0, 0, 1, 0, 1,   0, 1, 0, 2);
    step("hc_resume", 0, 0, 0, 0, 0, 0,   1, 1, 0, 2);
    step("hc_abort",  0, 0, 0, 0, 1, 0,   0, 0, 0, 0);

    // Abort together with the final carry wins
    step("a_start",   0, 1, 2, 0, 0, 0,   1, 1, 0, 2);
    step("a_c1",      0, 0, 0, 0, 0, 1,   1, 1, 0, 1);
    step("a_abort",   0, 0, 0, 0, 1, 1,   0, 0, 0, 0);
    step("a_nodone",  0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
`endif

    // Zero-period command goes straight to DONE; start during DONE is dropped
    step("z_start",   0, 1, 0, 0, 0, 0,   0, 1, 1, 0);
    step("z_ign_st",  0, 1, 5, 0, 0, 0,   0, 0, 0, 0);
    step("z_idle",    0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    // Reset mid-command discards it
    step("r_start",   0, 1, 4, 0, 0, 0,   1, 1, 0, 4);
    step("r_c1",      0, 0, 0, 0, 0, 1,   1, 1, 0, 3);
    step("r_reset",   1, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    step("r_after",   0, 0, 0, 0, 0, 1,   0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/period_scheduler.md
# period_scheduler

Controller that sequences an external cascade of up-counter stages used as a prescaler. It drives the chain's count enable (`ei`), counts the chain's terminal carries (`eu`), and signals completion after a commanded number of full prescaler periods. It sits between command logic and the counter chain: the chain stays a passive datapath, and this block decides when it runs.

## Interface
- `W`, default 8: width of the period count and of `remaining`.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command request; sampled only in IDLE.
- `periods`  in  W  number of carries to wait; captured when `start` is accepted.
- `hold`  in  1  pause request; while high in RUN, `ei` is low.
- `abort`  in  1  cancel the current command; return to IDLE without `done`.
- `eu`  in  1  carry from the counter chain.
- `ei`  out  1  enable to the counter chain.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `remaining`  out  W  carries still to be counted.

## Operation
- FSM states are IDLE, RUN and DONE. All outputs are registered.
- **Reset values:** state IDLE, `ei`=0, `busy`=0, `done`=0, `remaining`=0. Reset mid-command discards the command immediately. Reset has priority over every other input.
- **IDLE:**
  - `start`=1 with `periods`≠0: latch `periods` into `remaining` and go to RUN.
  - `start`=1 with `periods`=0: go to DONE directly; `ei` is never asserted.
- **RUN:**
  - `ei` = ~`hold` (registered, so it follows `hold` with one cycle of latency).
  - A carry counts only when `eu`=1 and `ei`=1 in the same cycle. `eu` while `ei`=0 is ignored.
  - On a counted carry, `remaining` decrements by 1.
  - A counted carry with `remaining`=1 moves to DONE, sets `remaining` to 0 and drops `ei`.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **abort:** effective in RUN only; next state is IDLE and `ei` drops. If `abort` and the final counted carry arrive in the same cycle, `abort` wins and `done` is not pulsed.
- `start` outside IDLE is ignored; it is not queued. `abort` in IDLE or DONE is ignored.
- `remaining` never wraps. It cannot decrement below 0 because the transition to DONE happens at 1.

## Timing
- `start` sampled at edge k: RUN and `ei`=1 from edge k+1. `busy` rises at k+1.
- `periods`=0: DONE at k+1, `done`=1 during cycle k+1, IDLE at k+2.
- Final counted carry sampled at edge m: `done`=1 during cycle m+1, IDLE at m+2.
- `hold` raised at edge h: `ei`=0 from h+1. A carry sampled at edge h still counts.
- The earliest new `start` after a completion is accepted at edge m+2.

## Configuration
- **Macro `PERIOD_RELOAD_EN`:**
  - **Defined:** on the final counted carry, reload `remaining` from the latched `periods` and stay in RUN with `ei` held high. `done` pulses one cycle after each completed command. The block loops until `abort` or `reset`. A command with `periods`=0 still takes the single DONE→IDLE path and never loops.
  - **Undefined:** one-shot behaviour as described above. The latched-periods register is not instantiated.

## Test plan
- Reset held for 2 cycles, then released → `ei`=0, `busy`=0, `done`=0, `remaining`=0 on the first cycle after release.
- `start`=1 with `periods`=3, `eu` pulsed on 3 cycles with `hold`=0 → `remaining` goes 3→2→1→0, `done` is high for 1 cycle after the third carry, and `busy` falls the following cycle.
- `periods`=2, `hold` high for 4 cycles between the carries, `eu` forced high during the hold → those carries are ignored, `remaining` stays at 1, and `done` fires only after the next carry with `ei`=1.
- `periods`=2, `abort` asserted in the same cycle as the second carry → no `done` pulse, state IDLE, `ei`=0.
- `start` with `periods`=0 → `done` pulses at k+1, `ei` stays 0 throughout; a second `start` during DONE is ignored.
- With `PERIOD_RELOAD_EN` defined, `periods`=2 and 6 carries → 3 `done` pulses, `remaining` reloads to 2 after each; `abort` then gives IDLE.
